// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receive sequencer with a valid/ack holding register.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (sense set by PARITY_ODD).
`timescale 1ns/1ps
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OS_RATE    = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);
    localparam int TW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST = TW'(OS_RATE - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OS_RATE / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t st_q, st_d;
    logic sync_q, rxs_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
    logic valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, ovr_q, ovr_d;
    logic done, pe_calc;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    assign pe_calc = ^sh_q ^ par_q ^ PARITY_ODD;
`else
    assign pe_calc = 1'b0;
`endif

    always_comb begin
        st_d   = st_q;
        tick_d = tick_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        done   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d  = par_q;
`endif
        if (os_tick) begin
            tick_d = tick_q + 1'b1;
            case (st_q)
                IDLE: begin
                    tick_d = '0;
                    st_d   = rxs_q ? IDLE : START;
                end
                START: if (tick_q == T_HALF) begin
                    tick_d = '0;
                    bit_d  = '0;
                    st_d   = rxs_q ? IDLE : DATA;
                end
                DATA: if (tick_q == T_LAST) begin
                    tick_d = '0;
                    sh_d   = {rxs_q, sh_q[DATA_BITS-1:1]};
                    bit_d  = bit_q + 1'b1;
                    st_d   = (bit_q == BW'(DATA_BITS - 1)) ? AFTER_DATA : DATA;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick_q == T_LAST) begin
                    tick_d = '0;
                    par_d  = rxs_q;
                    st_d   = STOP;
                end
`endif
                STOP: if (tick_q == T_LAST) begin
                    tick_d = '0;
                    done   = 1'b1;
                    st_d   = rxs_q ? IDLE : BREAK;
                end
                BREAK: begin
                    tick_d = '0;
                    st_d   = rxs_q ? IDLE : BREAK;
                end
                default: st_d = IDLE;
            endcase
        end
    end

    // A frame finishing on the same clk as an ack replaces the byte instead of overrunning.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        ovr_d   = ovr_q;
        if (valid_q && rx_ack) begin
            valid_d = 1'b0;
            fe_d    = 1'b0;
            pe_d    = 1'b0;
            ovr_d   = 1'b0;
        end
        if (done) begin
            if (!valid_q || rx_ack) begin
                data_d  = sh_q;
                valid_d = 1'b1;
                fe_d    = !rxs_q;
                pe_d    = pe_calc;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            sync_q  <= 1'b1;
            rxs_q   <= 1'b1;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            sync_q  <= rxd;
            rxs_q   <= sync_q;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end
`endif

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_frame_err  = fe_q;
    assign rx_parity_err = pe_q;
    assign rx_overrun    = ovr_q;
    assign rx_busy       = st_q != IDLE;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench; frames are pushed as expected bytes when sent and popped
// by a monitor whenever the DUT presents a new byte.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    localparam int DB = 8;
    localparam int OS = 16;
    localparam int TP = 4;
    localparam int BITCLK = OS * TP;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // rxd falls just before a tick edge; the synchroniser makes the next tick the detection tick.
    localparam int LAT = TP * (1 + OS / 2 + (DB + 1 + NPAR) * OS) + 1;

    logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, rx_ack = 1'b0;
    wire os_tick;
    logic [DB-1:0] rx_data;
    logic rx_valid, rx_frame_err, rx_overrun, rx_parity_err, rx_busy;
    int cyc = 0, ack_at = -1, errs = 0, checks = 0;

    typedef struct {
        logic [7:0] d;
        bit fe;
        bit pe;
        int t;
    } exp_t;
    exp_t q[$];

    assign os_tick = (cyc % TP == 0);
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial forever begin
        @(negedge clk);
        rx_ack = (cyc == ack_at);
    end

    uart_rx_ctrl #(.DATA_BITS(DB), .OS_RATE(OS), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rxd(rxd), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err), .rx_busy(rx_busy)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endtask

    function automatic bit gp(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit stop, input bit par, input int low_extra,
                        input int ack_off, input bit expect_it);
        int t0;
        exp_t e;
        do begin
            @(posedge clk);
            #1;
        end while (cyc % TP != 0);
        t0 = cyc;
        if (ack_off >= 0) ack_at = t0 + ack_off;
        if (expect_it) begin
            e.d = d;
            e.fe = !stop;
`ifdef UART_RX_PARITY_EN
            e.pe = (^d) ^ par;
`else
            e.pe = 1'b0 & par;
`endif
            e.t = t0 + LAT;
            q.push_back(e);
        end
        hold(1'b0, BITCLK);
        for (int i = 0; i < DB; i++) hold(d[i], BITCLK);
`ifdef UART_RX_PARITY_EN
        hold(par, BITCLK);
`endif
        hold(stop, BITCLK);
        if (low_extra > 0) hold(1'b0, low_extra);
        hold(1'b1, 20);
    endtask

    task automatic ack();
        ack_at = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        bit pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid === 1'b1 && (!pv || rx_ack)) begin
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_frame: got rx_data %0h with nothing expected", rx_data);
                end else begin
                    e = q.pop_front();
                    chk("data", rx_data, e.d);
                    chk("frame_err", rx_frame_err, e.fe);
                    chk("parity_err", rx_parity_err, e.pe);
                    chk("latency", cyc, e.t);
                end
            end
            pv = (rx_valid === 1'b1);
        end
    end

    initial begin
        logic [7:0] d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_fe", rx_frame_err, 0);
        chk("rst_ovr", rx_overrun, 0);
        chk("rst_pe", rx_parity_err, 0);
        chk("rst_busy", rx_busy, 0);
        rst = 1'b0;
        hold(1'b1, 10);

        send(8'hA5, 1'b1, gp(8'hA5), 0, -1, 1'b1);
        chk("a5_valid", rx_valid, 1);
        chk("a5_ovr", rx_overrun, 0);
        ack();
        chk("a5_ack_valid", rx_valid, 0);

        do begin
            @(posedge clk);
            #1;
        end while (cyc % TP != 0);
        hold(1'b0, 10);
        chk("glitch_busy", rx_busy, 1);
        hold(1'b0, 2);
        hold(1'b1, 28);
        chk("glitch_idle", rx_busy, 0);
        chk("glitch_valid", rx_valid, 0);

        fork
            send(8'h3C, 1'b0, gp(8'h3C), 40 * BITCLK, -1, 1'b1);
            begin
                repeat (LAT + 1000) @(posedge clk);
                #1;
                chk("break_busy", rx_busy, 1);
            end
        join
        chk("break_data", rx_data, 8'h3C);
        chk("break_fe", rx_frame_err, 1);
        chk("break_no_second", rx_overrun, 0);
        chk("break_idle", rx_busy, 0);
        ack();
        send(8'h55, 1'b1, gp(8'h55), 0, -1, 1'b1);
        ack();

        send(8'h11, 1'b1, gp(8'h11), 0, -1, 1'b1);
        send(8'h22, 1'b1, gp(8'h22), 0, -1, 1'b0);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_flag", rx_overrun, 1);
        chk("ovr_valid", rx_valid, 1);
        ack();
        chk("ovr_ack_valid", rx_valid, 0);
        chk("ovr_ack_flag", rx_overrun, 0);
        send(8'h33, 1'b1, gp(8'h33), 0, LAT - 1, 1'b1);
        chk("ack_cmp_valid", rx_valid, 1);
        chk("ack_cmp_ovr", rx_overrun, 0);
        send(8'h44, 1'b1, gp(8'h44), 0, LAT - 1, 1'b1);
        chk("replace_data", rx_data, 8'h44);
        chk("replace_ovr", rx_overrun, 0);

        fork
            send(8'hF0, 1'b1, gp(8'hF0), 0, -1, 1'b0);
            begin
                repeat (4 * BITCLK + 40) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("mid_rst_valid", rx_valid, 0);
                chk("mid_rst_data", rx_data, 0);
                chk("mid_rst_busy", rx_busy, 0);
                chk("mid_rst_fe", rx_frame_err, 0);
                chk("mid_rst_pe", rx_parity_err, 0);
                chk("mid_rst_ovr", rx_overrun, 0);
                rst = 1'b0;
            end
        join
        send(8'h0F, 1'b1, gp(8'h0F), 0, -1, 1'b1);
        ack();

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, 0, -1, 1'b1);
        chk("par_good", rx_parity_err, 0);
        ack();
        send(8'h07, 1'b1, 1'b0, 0, -1, 1'b1);
        chk("par_bad", rx_parity_err, 1);
        ack();
`endif

        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            send(d, ($urandom % 4) != 0, 1'($urandom), 0, -1, 1'b1);
            chk("rand_valid", rx_valid, 1);
            ack();
        end

        repeat (10) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
